// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature front end for the position up/down counter.
// Synchronises and glitch-filters channels A and B, then decodes Gray-code
// transitions into a one-cycle step strobe plus a held direction level.
// Double-bit transitions raise err and never produce a step.
//
// Optional feature macro: QDEC_ERR_CNT_EN (adds the saturating err_count port).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   a_in/b_in  asynchronous quadrature channels
//   step       one-cycle pulse per legal transition
//   up_down    direction of the last legal step (1 = up)
//   err        one-cycle pulse per illegal (double-bit) transition
//   locked     high once the initial input state has been captured
//   err_count  saturating illegal-transition count (QDEC_ERR_CNT_EN only)
module quad_step_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned ERR_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    output logic step,
    output logic up_down,
    output logic err,
    output logic locked
`ifdef QDEC_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0] err_count
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN);

    // Elaboration-time parameter range checks
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("quad_step_decoder: SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filt
        $error("quad_step_decoder: FILTER_LEN must be 1..15");
    end
    if (ERR_W < 1) begin : g_bad_errw
        $error("quad_step_decoder: ERR_W must be at least 1");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  a_sync_q;
    logic [SYNC_STAGES-1:0]  b_sync_q;
    logic [1:0]              samp;       // {a_s, b_s}
    logic [1:0]              filt_q;     // filtered {A, B}
    logic [1:0]              filt_d;
    logic [1:0]              ref_q;      // filtered pair seen on the previous cycle
    logic [1:0][CNT_W-1:0]   cnt_q;
    logic [1:0][CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]        stab_q;     // INIT: consecutive cycles with an unchanged sample pair
    logic [CNT_W-1:0]        stab_d;
    logic                    lock_now;
    logic                    is_fwd;
    logic                    is_rev;
    logic                    is_dbl;

    // Synchroniser chains; the last stage is the sampled channel value
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
        end
    end

    assign samp = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    // Per-channel filter: the filtered bit follows the sample only after
    // FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (samp[i] != filt_q[i]) begin
                if (CNT_W'(cnt_q[i] + CNT_W'(1)) == FILT_MAX) begin
                    filt_d[i] = samp[i];
                end else begin
                    cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
                end
            end
        end
    end

    // INIT tracks the sample pair directly; lock once it has held FILTER_LEN cycles
    assign stab_d   = (samp == filt_q) ? CNT_W'(stab_q + CNT_W'(1)) : CNT_W'(1);
    assign lock_now = (stab_d == FILT_MAX);

    // Gray decode of previous pair -> current filtered pair
    always_comb begin
        is_fwd = 1'b0;
        is_rev = 1'b0;
        is_dbl = 1'b0;
        case ({ref_q, filt_q})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_dbl = 1'b1;
            default: ;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            filt_q  <= '0;
            ref_q   <= '0;
            cnt_q   <= '0;
            stab_q  <= '0;
            step    <= 1'b0;
            err     <= 1'b0;
            locked  <= 1'b0;
            up_down <= 1'b1;
`ifdef QDEC_ERR_CNT_EN
            err_count <= '0;
`endif
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    filt_q <= samp;
                    ref_q  <= samp;
                    cnt_q  <= '0;
                    stab_q <= stab_d;
                    if (lock_now) begin
                        state_q <= ST_TRACK;
                        locked  <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                    ref_q  <= filt_q;
                    if (is_fwd) begin
                        step    <= 1'b1;
                        up_down <= 1'b1;
                    end else if (is_rev) begin
                        step    <= 1'b1;
                        up_down <= 1'b0;
                    end else if (is_dbl) begin
                        err <= 1'b1;
`ifdef QDEC_ERR_CNT_EN
                        if (err_count != '1) begin
                            err_count <= ERR_W'(err_count + ERR_W'(1));
                        end
`endif
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a behavioural model predicts lock,
// step and err events into a queue; a monitor pops and compares them.
module tb_quad_step_decoder;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FL   = 4;
    localparam int unsigned EW   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_in = 1'b1;
    logic b_in = 1'b1;
    logic step, up_down, err, locked;
`ifdef QDEC_ERR_CNT_EN
    logic [EW-1:0] err_count;
`endif

    always #5 clk = ~clk;

    quad_step_decoder #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FL),
        .ERR_W      (EW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_in   (a_in),
        .b_in   (b_in),
        .step   (step),
        .up_down(up_down),
        .err    (err),
        .locked (locked)
`ifdef QDEC_ERR_CNT_EN
        ,
        .err_count(err_count)
`endif
    );

    // kind: 0 = lock, 1 = step, 2 = err
    typedef struct {
        int unsigned at;
        int          kind;
        logic        dir;
        int unsigned ecnt;
    } ev_t;

    ev_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned ecount = 0;
    bit          started = 0;

    // Model state
    logic [1:0]  dly[$];
    logic [1:0]  win[$];
    bit          m_track;
    logic [1:0]  m_filt;
    logic        m_dir = 1'b1;
    int unsigned m_errs;

    // Position of a pair along the forward cycle 00,01,11,10
    function automatic int pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void push_ev(input int unsigned at, input int kind);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.dir  = m_dir;
        e.ecnt = m_errs;
        sb.push_back(e);
    endfunction

    // Reference model: evaluated once per rising edge from the inputs it sees
    initial begin
        forever begin
            logic [1:0] s;
            logic [1:0] nf;
            bit         same;
            int         d;
            @(posedge clk);
            ecount++;
            if (reset) begin
                dly.delete();
                for (int i = 0; i < int'(SYNC); i++) dly.push_back(2'b00);
                win.delete();
                m_track = 0;
                m_filt  = 2'b00;
                m_dir   = 1'b1;
                m_errs  = 0;
                sb.delete();
                started = 1;
            end else if (started) begin
                dly.push_back({a_in, b_in});
                s = dly.pop_front();
                win.push_back(s);
                if (win.size() > int'(FL)) void'(win.pop_front());
                if (!m_track) begin
                    same = 1;
                    foreach (win[i]) if (win[i] != s) same = 0;
                    if (win.size() == int'(FL) && same) begin
                        m_track = 1;
                        m_filt  = s;
                        push_ev(ecount, 0);
                    end
                end else begin
                    nf = m_filt;
                    for (int c = 0; c < 2; c++) begin
                        same = 1;
                        foreach (win[i]) if (win[i][c] == m_filt[c]) same = 0;
                        if (win.size() == int'(FL) && same) nf[c] = ~m_filt[c];
                    end
                    if (nf != m_filt) begin
                        d = (pos(nf) - pos(m_filt) + 4) % 4;
                        if (d == 2) begin
                            if (m_errs < (1 << EW) - 1) m_errs++;
                            push_ev(ecount + 1, 2);
                        end else begin
                            m_dir = (d == 1);
                            push_ev(ecount + 1, 1);
                        end
                        m_filt = nf;
                    end
                end
            end
        end
    end

    task automatic observe(input int kind);
        ev_t e;
        checks++;
        if (sb.size() == 0 || sb[0].at != ecount) begin
            errors++;
            $display("FAIL unexpected_event edge=%0d got kind=%0d, none predicted", ecount, kind);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || up_down !== e.dir
`ifdef QDEC_ERR_CNT_EN
                || (kind == 2 && err_count !== EW'(e.ecnt))
`endif
               ) begin
                errors++;
                $display("FAIL event edge=%0d got kind=%0d up_down=%b, expected kind=%0d up_down=%b",
                         ecount, kind, up_down, e.kind, e.dir);
            end
        end
    endtask

    // Monitor: compares every DUT event against the scoreboard head
    initial begin
        bit lk_prev = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!started) continue;
            while (sb.size() > 0 && sb[0].at < ecount) begin
                ev_t e;
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event expected kind=%0d at edge %0d, got nothing", e.kind, e.at);
            end
            if (locked && !lk_prev) observe(0);
            if (step) observe(1);
            if (err) observe(2);
            lk_prev = locked;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        a_in = p[1];
        b_in = p[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_step"}, 32'(step), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_up_down"}, 32'(up_down), 32'd1);
`ifdef QDEC_ERR_CNT_EN
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
    endtask

    task automatic do_reset(input logic [1:0] p, input string tag);
        a_in  = p[1];
        b_in  = p[0];
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs(tag);
    endtask

    initial begin
        // Power-up at 11: lock with no error
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("rst11");
        hold(2'b11, 15);
        chk("lock11", 32'(locked), 32'd1);

        // Forward then reverse sequences from 00
        do_reset(2'b00, "rst00");
        hold(2'b00, 8);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        chk("dir_fwd", 32'(up_down), 32'd1);
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
        chk("dir_rev_held", 32'(up_down), 32'd0);

        // Glitch shorter than the filter, then one exactly FILTER_LEN long
        hold(2'b10, int'(FL) - 1); hold(2'b00, 12);
        hold(2'b10, int'(FL));     hold(2'b00, 12);

        // Double-bit jumps
        hold(2'b11, 10); hold(2'b00, 10);

        // Reset landing on the edge that would emit a step
        a_in = 1'b0;
        b_in = 1'b1;
        repeat (SYNC + FL) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("rst_mid");
        hold(2'b01, 12);

        // Randomised holds, including sub-filter glitches and double jumps
        for (int i = 0; i < 300; i++) begin
            hold(2'($urandom()), int'($urandom_range(1, 12)));
        end
        hold(2'b00, 12);

`ifdef QDEC_ERR_CNT_EN
        // 300 illegal jumps saturate the counter
        do_reset(2'b00, "rst_sat");
        hold(2'b00, 8);
        for (int i = 0; i < 150; i++) begin
            hold(2'b11, 6);
            hold(2'b00, 6);
        end
        hold(2'b00, 6);
        chk("err_count_sat", 32'(err_count), 32'(255));
`endif

        hold(2'b00, 20);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
